// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq.
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// opcode and operands only need to be stable in that cycle. in_valid is
// ignored while in_ready is low. out_valid is a one-cycle pulse marking that
// reg_out/reg_out_hi/SREG were updated by a completing operation.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       function_select_lines;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] reg_out;
  logic [WIDTH-1:0] reg_out_hi;
  logic [3:0]       SREG;
  logic             out_valid;

  modport master (
    output in_valid, function_select_lines, operandA, operandB,
    input  in_ready, reg_out, reg_out_hi, SREG, out_valid
  );

  modport slave (
    input  in_valid, function_select_lines, operandA, operandB,
    output in_ready, reg_out, reg_out_hi, SREG, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus a multi-cycle
// unsigned shift-add multiplier. SREG = {V, N, C, Z}.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus,
  output logic     state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SBC = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   res_q, res_hi_q;
  logic [3:0]         sreg_q;
  logic               out_valid_q;
  logic               accept, mul_done;

  logic [3:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_wr, flag_zn, cin_use;
  logic [3:0]         alu_flags;

  assign op        = bus.function_select_lines;
  assign a         = bus.operandA;
  assign b         = bus.operandB;
  assign accept    = bus.in_valid && bus.in_ready;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.reg_out    = res_q;
  assign bus.reg_out_hi = res_hi_q;
  assign bus.SREG       = sreg_q;
  assign bus.out_valid  = out_valid_q;
  assign state_dbg      = (state_q == MUL_BUSY);

  // One partial-product step: add the shifted multiplicand when the current
  // multiplier bit is set.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; MUL finishes on the WIDTH-th busy edge (cnt = WIDTH-1).
  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    case (state_q)
      IDLE:     if (accept && op == OP_MUL) state_d = MUL_BUSY;
      MUL_BUSY: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = IDLE;
          mul_done = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Single-cycle datapath: result, write enable and flags for the opcode
  // presented this cycle. Carry-in comes from the currently registered SREG.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_wr    = 1'b0;
    flag_zn   = 1'b0;
    alu_flags = 4'b0000;
    cin_use   = sreg_q[1] && (op == OP_ADC || op == OP_SBC);
    case (op)
      OP_ADD, OP_ADC: begin
        sum          = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_use};
        alu_res      = sum[WIDTH-1:0];
        alu_wr       = 1'b1;
        flag_zn      = 1'b1;
        alu_flags[1] = sum[WIDTH];
        alu_flags[3] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        sum          = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_use};
        alu_res      = sum[WIDTH-1:0];
        alu_wr       = (op != OP_CMP);
        flag_zn      = 1'b1;
        alu_flags[1] = sum[WIDTH];
        alu_flags[3] = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  begin alu_res = a | b; alu_wr = 1'b1; flag_zn = 1'b1; end
      OP_AND: begin alu_res = a & b; alu_wr = 1'b1; flag_zn = 1'b1; end
      OP_XOR: begin alu_res = a ^ b; alu_wr = 1'b1; flag_zn = 1'b1; end
      OP_NOT: begin alu_res = ~a;    alu_wr = 1'b1; flag_zn = 1'b1; end
      OP_SHL: begin
        alu_res      = a << 1;
        alu_wr       = 1'b1;
        flag_zn      = 1'b1;
        alu_flags[1] = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res      = a >> 1;
        alu_wr       = 1'b1;
        flag_zn      = 1'b1;
        alu_flags[1] = a[0];
      end
      default: ;
    endcase
    if (flag_zn) begin
      alu_flags[0] = (alu_res == '0);
      alu_flags[2] = alu_res[WIDTH-1];
    end
  end

  // Result/status registers and multiplier datapath; outputs only move on a
  // single-cycle accept or on MUL completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q       <= '0;
      res_hi_q    <= '0;
      sreg_q      <= 4'b0000;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          cnt_q    <= '0;
          acc_q    <= '0;
          mcand_q  <= {{WIDTH{1'b0}}, a};
          mplier_q <= b;
        end else begin
          out_valid_q <= 1'b1;
          sreg_q      <= alu_flags;
          if (alu_wr) res_q <= alu_res;
        end
      end else if (state_q == MUL_BUSY) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (mul_done) begin
          {res_hi_q, res_q} <= acc_next;
          sreg_q      <= {2'b00, (acc_next[2*WIDTH-1:WIDTH] != '0), (acc_next == '0)};
          out_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
